sram_arbiter: RTL and testbench

Shares the single SRAM controller port between the UART host-command path and the i8080 memory-bus decoder. The host holds a session lock for the length of a command, while i8080 accesses are single transactions stalled through the CPU READY line. The block sits between the host controller/bus decoder and the SRAM controller, and owns every strobe, address and data word sent to the SRAM controller.

---
 rtl/sram_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single SRAM controller port between the UART host-command path
// and the i8080 memory-bus decoder. The host holds a session lock (host_req) for a whole
// command. CPU accesses are single transactions stalled through cpu_ready.
// Optional feature macro: SRAM_ARB_INTERLEAVE_EN. When it is defined, a pending CPU access
// may be serviced inside a host session whenever no host access is in flight. When it is
// not defined, the host lock is exclusive.
module sram_arbiter (
  input  logic        clk,
  input  logic        dev_rst,
  // host command path
  input  logic        host_req,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_dataout,
  output logic        host_busy,
  output logic        host_valid,
  output logic [7:0]  host_datain,
  // i8080 bus decoder
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ready,
  // SRAM controller
  output logic        mem_rd_stb,
  output logic        mem_wr_stb,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StHostOwn,
    StHostTxn,
    StCpuTxn
  } state_e;

  state_e      r_state;
  state_e      w_state_d;

  // CPU strobe synchronisers and edge-detect history
  logic        r_cpu_rd_meta, r_cpu_rd_sync, r_cpu_rd_prev;
  logic        r_cpu_wr_meta, r_cpu_wr_sync, r_cpu_wr_prev;
  logic        r_host_rd_prev, r_host_wr_prev;

  // pending requests and their kind
  logic        r_host_pend, r_host_is_wr;
  logic        r_cpu_pend, r_cpu_is_wr;

  // registered outputs
  logic        r_host_busy;
  logic        r_host_valid;
  logic [7:0]  r_host_datain;
  logic [7:0]  r_cpu_din;
  logic        r_cpu_ready;
  logic        r_mem_rd_stb;
  logic        r_mem_wr_stb;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;

  logic        w_host_rd_edge, w_host_wr_edge, w_host_edge;
  logic        w_cpu_rd_edge, w_cpu_wr_edge, w_cpu_edge;
  logic        w_host_pend_d, w_cpu_pend_d;
  logic        w_host_go, w_cpu_go;
  logic        w_issue_host, w_issue_cpu;
  logic        w_stb_now;
  logic        w_host_done, w_cpu_done;
  logic        w_cpu_may_own;

`ifdef SRAM_ARB_INTERLEAVE_EN
  assign w_cpu_may_own = 1'b1;
`else
  assign w_cpu_may_own = 1'b0;
`endif

  // Rising edges; a simultaneous read+write edge is treated as a write.
  assign w_host_rd_edge = host_read & ~r_host_rd_prev;
  assign w_host_wr_edge = host_write & ~r_host_wr_prev;
  assign w_host_edge    = w_host_rd_edge | w_host_wr_edge;
  assign w_cpu_rd_edge  = r_cpu_rd_sync & ~r_cpu_rd_prev;
  assign w_cpu_wr_edge  = r_cpu_wr_sync & ~r_cpu_wr_prev;
  assign w_cpu_edge     = w_cpu_rd_edge | w_cpu_wr_edge;

  assign w_stb_now = r_mem_rd_stb | r_mem_wr_stb;

  // A write is done on the first cycle after its strobe that sees the controller idle.
  assign w_host_done = (r_state == StHostTxn) &&
                       (r_host_is_wr ? (!w_stb_now && !mem_busy) : mem_valid);
  assign w_cpu_done  = (r_state == StCpuTxn) &&
                       (r_cpu_is_wr ? (!w_stb_now && !mem_busy) : mem_valid);

  assign w_host_pend_d = w_host_done ? 1'b0 : (r_host_pend | w_host_edge);
  assign w_cpu_pend_d  = w_cpu_done ? 1'b0 : (r_cpu_pend | w_cpu_edge);

  assign w_host_go = r_host_pend && !mem_busy;
  assign w_cpu_go  = r_cpu_pend && !mem_busy;

  // CPU wins every tie against the host.
  assign w_issue_cpu  = w_cpu_go &&
                        ((r_state == StIdle) || (w_cpu_may_own && (r_state == StHostOwn)));
  assign w_issue_host = w_host_go && (r_state == StHostOwn) && !w_issue_cpu;

  // Synchronise the CPU strobes and keep previous values for edge detection.
  always_ff @(posedge clk or negedge dev_rst) begin
    if (!dev_rst) begin
      r_cpu_rd_meta  <= 1'b0;
      r_cpu_rd_sync  <= 1'b0;
      r_cpu_rd_prev  <= 1'b0;
      r_cpu_wr_meta  <= 1'b0;
      r_cpu_wr_sync  <= 1'b0;
      r_cpu_wr_prev  <= 1'b0;
      r_host_rd_prev <= 1'b0;
      r_host_wr_prev <= 1'b0;
    end else begin
      r_cpu_rd_meta  <= cpu_rd;
      r_cpu_rd_sync  <= r_cpu_rd_meta;
      r_cpu_rd_prev  <= r_cpu_rd_sync;
      r_cpu_wr_meta  <= cpu_wr;
      r_cpu_wr_sync  <= r_cpu_wr_meta;
      r_cpu_wr_prev  <= r_cpu_wr_sync;
      r_host_rd_prev <= host_read;
      r_host_wr_prev <= host_write;
    end
  end

  // Next-state decode of the ownership FSM.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_issue_cpu) begin
          w_state_d = StCpuTxn;
        end else if (host_req) begin
          w_state_d = StHostOwn;
        end
      end
      StHostOwn: begin
        if (w_issue_cpu) begin
          w_state_d = StCpuTxn;
        end else if (w_issue_host) begin
          w_state_d = StHostTxn;
        end else if (!host_req && !r_host_pend) begin
          w_state_d = StIdle;
        end
      end
      StHostTxn: begin
        if (w_host_done) begin
          w_state_d = host_req ? StHostOwn : StIdle;
        end
      end
      StCpuTxn: begin
        if (w_cpu_done) begin
          w_state_d = host_req ? StHostOwn : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state, pending flags and all registered outputs.
  always_ff @(posedge clk or negedge dev_rst) begin
    if (!dev_rst) begin
      r_state       <= StIdle;
      r_host_pend   <= 1'b0;
      r_host_is_wr  <= 1'b0;
      r_cpu_pend    <= 1'b0;
      r_cpu_is_wr   <= 1'b0;
      r_host_busy   <= 1'b1;
      r_host_valid  <= 1'b0;
      r_host_datain <= 8'h00;
      r_cpu_din     <= 8'h00;
      r_cpu_ready   <= 1'b1;
      r_mem_rd_stb  <= 1'b0;
      r_mem_wr_stb  <= 1'b0;
      r_mem_addr    <= 16'h0000;
      r_mem_wdata   <= 8'h00;
    end else begin
      r_state     <= w_state_d;
      r_host_pend <= w_host_pend_d;
      r_cpu_pend  <= w_cpu_pend_d;
      if (!r_host_pend && w_host_edge) begin
        r_host_is_wr <= w_host_wr_edge;
      end
      if (!r_cpu_pend && w_cpu_edge) begin
        r_cpu_is_wr <= w_cpu_wr_edge;
      end

      // host is free only when it owns the lock with nothing outstanding
      r_host_busy <= !((w_state_d == StHostOwn) && !w_host_pend_d);

      // strobes are single-cycle; address and data hold until the next strobe
      r_mem_rd_stb <= 1'b0;
      r_mem_wr_stb <= 1'b0;
      if (w_issue_cpu) begin
        r_mem_rd_stb <= ~r_cpu_is_wr;
        r_mem_wr_stb <= r_cpu_is_wr;
        r_mem_addr   <= cpu_addr;
        r_mem_wdata  <= cpu_dout;
      end else if (w_issue_host) begin
        r_mem_rd_stb <= ~r_host_is_wr;
        r_mem_wr_stb <= r_host_is_wr;
        r_mem_addr   <= host_addr;
        r_mem_wdata  <= host_dataout;
      end

      r_host_valid <= 1'b0;
      if (w_host_done && !r_host_is_wr) begin
        r_host_valid  <= 1'b1;
        r_host_datain <= mem_rdata;
      end

      // READY drops one cycle after the request is pending, rises on completion
      if (w_cpu_done) begin
        r_cpu_ready <= 1'b1;
        if (!r_cpu_is_wr) begin
          r_cpu_din <= mem_rdata;
        end
      end else if (r_cpu_pend) begin
        r_cpu_ready <= 1'b0;
      end
    end
  end

  assign host_busy   = r_host_busy;
  assign host_valid  = r_host_valid;
  assign host_datain = r_host_datain;
  assign cpu_din     = r_cpu_din;
  assign cpu_ready   = r_cpu_ready;
  assign mem_rd_stb  = r_mem_rd_stb;
  assign mem_wr_stb  = r_mem_wr_stb;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed host vectors from a table plus hand-written CPU,
// arbitration-tie, session-lock and reset sequences against a small SRAM controller model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        dev_rst;
  logic        host_req, host_read, host_write;
  logic [15:0] host_addr;
  logic [7:0]  host_dataout;
  logic        host_busy, host_valid;
  logic [7:0]  host_datain;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_ready;
  logic        mem_rd_stb, mem_wr_stb;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_busy, mem_valid;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk          (clk),
    .dev_rst      (dev_rst),
    .host_req     (host_req),
    .host_read    (host_read),
    .host_write   (host_write),
    .host_addr    (host_addr),
    .host_dataout (host_dataout),
    .host_busy    (host_busy),
    .host_valid   (host_valid),
    .host_datain  (host_datain),
    .cpu_rd       (cpu_rd),
    .cpu_wr       (cpu_wr),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .cpu_din      (cpu_din),
    .cpu_ready    (cpu_ready),
    .mem_rd_stb   (mem_rd_stb),
    .mem_wr_stb   (mem_wr_stb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_busy     (mem_busy),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata)
  );

  // SRAM controller model: busy for 3 cycles after a strobe, read data valid on the last.
  logic [7:0] mem_arr [0:255];
  int         m_cnt;
  logic       m_is_rd;
  always @(posedge clk or negedge dev_rst) begin
    if (!dev_rst) begin
      mem_busy  <= 1'b0;
      mem_valid <= 1'b0;
      mem_rdata <= 8'h00;
      m_cnt     <= 0;
      m_is_rd   <= 1'b0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 0) ? 8'hC3 : 8'h00;
    end else begin
      mem_valid <= 1'b0;
      if (mem_rd_stb || mem_wr_stb) begin
        mem_busy <= 1'b1;
        m_cnt    <= 2;
        m_is_rd  <= mem_rd_stb;
        if (mem_wr_stb) mem_arr[mem_addr[7:0]] <= mem_wdata;
        else mem_rdata <= mem_arr[mem_addr[7:0]];
      end else if (mem_busy) begin
        if (m_cnt == 1) begin
          mem_valid <= m_is_rd;
          m_cnt     <= 0;
        end else if (m_cnt == 0) begin
          mem_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Strobe log and host_valid counter.
  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } stb_t;
  stb_t log_q[$];
  int   n_valid = 0;
  always @(posedge clk) begin
    if (mem_rd_stb || mem_wr_stb) log_q.push_back('{mem_wr_stb, mem_rd_stb, mem_addr, mem_wdata});
    if (host_valid) n_valid <= n_valid + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_host_busy"}, host_busy, 1);
    chk({p, "_cpu_ready"}, cpu_ready, 1);
    chk({p, "_host_valid"}, host_valid, 0);
    chk({p, "_rd_stb"}, mem_rd_stb, 0);
    chk({p, "_wr_stb"}, mem_wr_stb, 0);
    chk({p, "_host_datain"}, host_datain, 0);
    chk({p, "_cpu_din"}, cpu_din, 0);
    chk({p, "_mem_addr"}, mem_addr, 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic wait_host_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (!host_busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk({nm, "_host_idle"}, ok, 1);
  endtask

  task automatic wait_ready(output bit ok, output bit prev_v);
    ok = 0;
    prev_v = 0;
    for (int i = 0; i < 80; i++) begin
      prev_v = mem_valid;
      tick();
      if (cpu_ready) begin
        ok = 1;
        break;
      end
    end
  endtask

  // One host access inside an open session; checks strobe kind/address and read data.
  task automatic do_host(input string nm, input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic exp_wr, input logic [7:0] exp_data);
    int   base, v0;
    bit   done, vfall;
    stb_t e;
    base = log_q.size();
    v0 = n_valid;
    host_addr = addr;
    host_dataout = wdata;
    host_write = wr;
    host_read = rd;
    done = 0;
    vfall = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!host_busy) begin
        done = 1;
        vfall = host_valid;
        break;
      end
    end
    host_read = 0;
    host_write = 0;
    tick();
    chk({nm, "_done"}, done, 1);
    chk({nm, "_nstb"}, log_q.size() - base, 1);
    if (log_q.size() > base) begin
      e = log_q[base];
      chk({nm, "_wr_stb"}, e.wr, exp_wr);
      chk({nm, "_rd_stb"}, e.rd, !exp_wr);
      chk({nm, "_addr"}, e.addr, addr);
      if (exp_wr) chk({nm, "_wdata"}, e.wdata, wdata);
    end
    chk({nm, "_nvalid"}, n_valid - v0, exp_wr ? 0 : 1);
    if (!exp_wr) begin
      chk({nm, "_valid_at_free"}, vfall, 1);
      chk({nm, "_datain"}, host_datain, exp_data);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_wr;
    logic [7:0]  exp_data;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok, pv, bad;
    int   base;
    stb_t e;

    vecs[0] = '{1'b1, 1'b0, 16'h1234, 8'h5A, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 8'h77, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, 8'h77};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 8'hA5, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'hC3};

    dev_rst = 0;
    host_req = 0; host_read = 0; host_write = 0; host_addr = 0; host_dataout = 0;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_dout = 0;
    tick(); tick(); tick();
    chk_reset_vals("rst0");
    dev_rst = 1;
    tick(); tick();

    // CPU read on an idle arbiter: READY low 4 cycles after the pin strobe
    base = log_q.size();
    cpu_addr = 16'h0000;
    cpu_rd = 1;
    tick(); tick(); tick();
    chk("cpu_rd_ready_hi_at3", cpu_ready, 1);
    tick();
    chk("cpu_rd_ready_lo_at4", cpu_ready, 0);
    wait_ready(ok, pv);
    chk("cpu_rd_ready_back", ok, 1);
    chk("cpu_rd_ready_after_valid", pv, 1);
    chk("cpu_rd_din", cpu_din, 8'hC3);
    chk("cpu_rd_nstb", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      e = log_q[base];
      chk("cpu_rd_is_rd", e.rd, 1);
      chk("cpu_rd_addr", e.addr, 16'h0000);
    end
    cpu_rd = 0;
    tick(); tick(); tick(); tick();

    // host session driven from the vector table
    host_req = 1;
    tick();
    wait_host_idle("sess_open");
    for (int i = 0; i < 7; i++) begin
      do_host($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_wr, vecs[i].exp_data);
    end
    host_req = 0;
    tick(); tick();

    // host_req and a CPU write arrive together in IDLE: CPU goes first
    base = log_q.size();
    cpu_addr = 16'h2020;
    cpu_dout = 8'h99;
    cpu_wr = 1;
    tick(); tick(); tick();
    host_addr = 16'h1234;
    host_read = 1;
    host_req = 1;
    wait_ready(ok, pv);
    chk("tie_cpu_done", ok, 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!host_busy) begin
        ok = 1;
        break;
      end
    end
    chk("tie_host_done", ok, 1);
    host_read = 0;
    cpu_wr = 0;
    tick();
    chk("tie_nstb", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      e = log_q[base];
      chk("tie_first_is_cpu_wr", e.wr, 1);
      chk("tie_first_addr", e.addr, 16'h2020);
      chk("tie_first_wdata", e.wdata, 8'h99);
      e = log_q[base + 1];
      chk("tie_second_is_rd", e.rd, 1);
      chk("tie_second_addr", e.addr, 16'h1234);
    end
    chk("tie_host_data", host_datain, 8'h5A);
    tick(); tick(); tick();

    // CPU read while the host holds the lock
    wait_host_idle("lock_open");
    base = log_q.size();
`ifdef SRAM_ARB_INTERLEAVE_EN
    do_host("il_wr", 1'b1, 1'b0, 16'h0140, 8'h11, 1'b1, 8'h00);
    cpu_addr = 16'h2020;
    cpu_rd = 1;
    tick(); tick(); tick(); tick();
    chk("il_ready_lo", cpu_ready, 0);
    bad = 0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpu_ready) begin
        ok = 1;
        break;
      end
      if (!host_busy) bad = 1;
    end
    chk("il_cpu_done", ok, 1);
    chk("il_busy_during_cpu", bad, 0);
    chk("il_cpu_din", cpu_din, 8'h99);
    cpu_rd = 0;
    tick();
    do_host("il_rd", 1'b0, 1'b1, 16'h0140, 8'h00, 1'b0, 8'h11);
    chk("il_nstb", log_q.size() - base, 3);
    if (log_q.size() >= base + 3) begin
      e = log_q[base + 1];
      chk("il_mid_is_cpu_rd", e.rd, 1);
      chk("il_mid_addr", e.addr, 16'h2020);
      e = log_q[base + 2];
      chk("il_last_addr", e.addr, 16'h0140);
    end
    host_req = 0;
    tick(); tick();
`else
    cpu_addr = 16'h2020;
    cpu_rd = 1;
    tick(); tick(); tick(); tick();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cpu_ready) bad = 1;
    end
    chk("lock_ready_held_lo", bad, 0);
    chk("lock_no_cpu_stb", log_q.size() - base, 0);
    do_host("lock_wr", 1'b1, 1'b0, 16'h0140, 8'h11, 1'b1, 8'h00);
    chk("lock_ready_still_lo", cpu_ready, 0);
    chk("lock_only_host_stb", log_q.size() - base, 1);
    host_req = 0;
    wait_ready(ok, pv);
    chk("lock_cpu_done", ok, 1);
    chk("lock_nstb", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      e = log_q[base + 1];
      chk("lock_cpu_is_rd", e.rd, 1);
      chk("lock_cpu_addr", e.addr, 16'h2020);
    end
    chk("lock_cpu_din", cpu_din, 8'h99);
    cpu_rd = 0;
    tick(); tick();
`endif
    tick(); tick(); tick();

    // reset in the middle of a host read
    host_req = 1;
    tick();
    wait_host_idle("rst_open");
    host_addr = 16'h0010;
    host_read = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rd_stb) begin
        ok = 1;
        break;
      end
    end
    chk("rst_strobe_seen", ok, 1);
    tick();
    dev_rst = 0;
    host_read = 0;
    host_req = 0;
    #1;
    chk_reset_vals("rst_mid");
    tick(); tick();
    dev_rst = 1;
    base = log_q.size();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!host_busy) bad = 1;
    end
    chk("rst_after_no_stb", log_q.size() - base, 0);
    chk("rst_after_busy_hi", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
